bit8_seq_mult: RTL and testbench

- 8-bit unsigned shift-and-add multiplier, multi-cycle, with a start/busy/done handshake.
- Sits directly downstream of the 8-bit operand-select mux stage (bit8_2to1mux). The mux outputs drive a and b; this block consumes them on start.
- Internally reuses bit8_2to1mux to select the accumulator's next value (hold vs add).

---
 rtl/mult_pkg.sv | 14 +
 rtl/bit8_2to1mux.sv | 11 +
 rtl/bit8_seq_mult.sv | 117 +++++++++++
 tb/tb_bit8_seq_mult.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the 8-bit sequential shift-and-add multiplier.
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int PWIDTH = 2 * WIDTH;
    localparam logic [3:0] ITER_LAST = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bit8_2to1mux.sv
// 8-bit two-input select: y = sel ? b : a.
module bit8_2to1mux (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sel,
    output logic [7:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/bit8_seq_mult.sv
// Unsigned shift-and-add multiplier: one multiplier bit per cycle, fixed 8-iteration
// latency, result registered on the last iteration and flagged by a one-cycle done.
module bit8_seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // Handshake: start is a level request seen only in IDLE; the edge that sees it
    // latches a/b. busy is high for the eight RUN cycles, done is high for exactly
    // one cycle while product holds the new result. Nothing is queued.

    state_t               state;
    state_t               state_nxt;

    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic [3:0]           count;

    logic [2*WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0]   acc_nxt;

    logic                 load;
    logic                 step;
    logic                 last;
    logic                 busy_nxt;
    logic                 done_nxt;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == ITER_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    // busy and done are registered from the next state so they never glitch.
    always_comb begin
        load     = (state == IDLE) && start;
        step     = (state == RUN);
        last     = step && (count == ITER_LAST);
        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    // Carry out of the add is dropped; 255*255 still fits in 16 bits.
    assign sum = acc + mcand;

    bit8_2to1mux u_acc_lo (
        .a   (acc[WIDTH-1:0]),
        .b   (sum[WIDTH-1:0]),
        .sel (mplr[0]),
        .y   (acc_nxt[WIDTH-1:0])
    );

    bit8_2to1mux u_acc_hi (
        .a   (acc[2*WIDTH-1:WIDTH]),
        .b   (sum[2*WIDTH-1:WIDTH]),
        .sel (mplr[0]),
        .y   (acc_nxt[2*WIDTH-1:WIDTH])
    );

    // ---------------- datapath and registered flags ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (load) begin
                mcand <= {{WIDTH{1'b0}}, a};
                mplr  <= b;
                acc   <= '0;
                count <= '0;
            end else if (step) begin
                acc   <= acc_nxt;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                count <= count + 4'd1;
            end
            // The final iteration's add goes straight into product.
            if (last) begin
                product <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bit8_seq_mult.sv
// Self-checking bench for bit8_seq_mult: scoreboard of expected products, latency,
// busy length, done width, product hold, async reset and start-ignored cases.
module tb_bit8_seq_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic prev_done = 1'b0;
    logic [15:0] held_prod = 16'h0000;

    logic [15:0] exp_q[$];
    int          lat_q[$];

    bit8_seq_mult dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at cycle %0d",
                     tag, obs, obs, expv, expv, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
            held_prod = 16'h0000;
        end else begin
            if (busy) begin
                busy_cnt++;
                check("product_hold", product, held_prod);
            end
            if (done) begin
                done_cnt++;
                check("done_width", {15'd0, prev_done}, 16'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 16'(exp_q.size()), 16'd1);
                end else begin
                    held_prod = exp_q.pop_front();
                    check("product", product, held_prod);
                    check("latency", 16'(cyc - lat_q.pop_front()), 16'd8);
                    check("busy_cycles", 16'(busy_cnt), 16'd8);
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 16'(n), 16'd0);
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(16'(x) * 16'(y));
        lat_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) check("done_timeout", 16'd0, 16'd1);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int d1;
        int d2;
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_product", product, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        reset = 1'b0;

        // basic operation and extremes
        start_op(8'd13, 8'd11);
        wait_done();
        start_op(8'd255, 8'd255);
        wait_done();
        start_op(8'd0, 8'd200);
        wait_done();

        // start and operand changes during RUN are ignored
        d0 = done_cnt;
        start_op(8'd6, 8'd7);
        repeat (2) @(negedge clk);
        a     = 8'd100;
        b     = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);
        check("one_done_only", 16'(done_cnt - d0), 16'd1);

        // asynchronous reset mid-operation
        start_op(8'd9, 8'd9);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_product", product, 16'h0000);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        start_op(8'd3, 8'd5);
        wait_done();

        // start held high: back-to-back operations
        wait_idle();
        a     = 8'd2;
        b     = 8'd3;
        start = 1'b1;
        exp_q.push_back(16'd6);
        lat_q.push_back(cyc + 1);
        wait_done();
        d1 = cyc;
        a  = 8'd4;
        b  = 8'd5;
        exp_q.push_back(16'd20);
        lat_q.push_back(cyc + 2);
        wait_done();
        d2 = cyc;
        start = 1'b0;
        check("done_spacing", 16'(d2 - d1), 16'd10);

        // random operands against a*b
        for (int i = 0; i < 200; i++) begin
            start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
